// File: rtl/four_or_if.sv
// ---------------------------------------------------------------------------
// four_or_if : signal bundle for the four_or OR-tree block.
//
// Handshake: there is no valid/ready pair. Every rising clk edge with rst_n=1
// is a transfer. The master presents a/b/c/d/clr before the edge, and the
// slave's registered results appear on e/f/g/any/any_rise/evt_cnt one cycle
// later. Neither side can stall the other.
//
// Signals
//   a, b, c, d : WIDTH-bit operands            (master -> slave)
//   clr        : synchronous event-count clear (master -> slave)
//   e, f, g    : registered a|b, c|d, e|f      (slave -> master)
//   any        : registered |(a|b|c|d)         (slave -> master)
//   any_rise   : one-cycle pulse on any 0->1   (slave -> master)
//   evt_cnt    : saturating count of rises     (slave -> master)
// ---------------------------------------------------------------------------
interface four_or_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) ();

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             clr;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic             any;
   logic             any_rise;
   logic [CNT_W-1:0] evt_cnt;

   // Stimulus side: drives operands and clear, observes results.
   modport master (
      output a, b, c, d, clr,
      input  e, f, g, any, any_rise, evt_cnt
   );

   // Block side: consumes operands and clear, drives results.
   modport slave (
      input  a, b, c, d, clr,
      output e, f, g, any, any_rise, evt_cnt
   );

endinterface

// File: rtl/four_or.sv
// ---------------------------------------------------------------------------
// four_or : registered bitwise OR tree over four WIDTH-bit operands.
//
// Produces the two pair results (e = a|b, f = c|d) and the final result
// (g = e|f), all registered with one cycle of latency. An "any bit set" flag
// follows g, any_rise pulses for one cycle when that flag goes 0->1, and
// evt_cnt counts those pulses, saturating at all-ones.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : four_or_if slave modport (operands, clr and registered results)
// ---------------------------------------------------------------------------
module four_or #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   four_or_if.slave    bus
);

   logic [WIDTH-1:0] e_n;
   logic [WIDTH-1:0] f_n;
   logic [WIDTH-1:0] g_n;
   logic             any_n;
   logic             rise_n;

   logic [WIDTH-1:0] e_q;
   logic [WIDTH-1:0] f_q;
   logic [WIDTH-1:0] g_q;
   logic             any_q;
   logic             any_rise_q;
   logic [CNT_W-1:0] evt_cnt_q;

   // Combinational OR tree. any_n is taken from g_n (next value), so the
   // registered any always agrees with the registered g.
   always_comb begin
      e_n    = bus.a | bus.b;
      f_n    = bus.c | bus.d;
      g_n    = e_n | f_n;
      any_n  = |g_n;
      // Rise is judged against the currently registered flag, so after reset
      // (any_q = 0) the first nonzero input cycle counts as a rise.
      rise_n = any_n & ~any_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q        <= '0;
         f_q        <= '0;
         g_q        <= '0;
         any_q      <= 1'b0;
         any_rise_q <= 1'b0;
      end else begin
         e_q        <= e_n;
         f_q        <= f_n;
         g_q        <= g_n;
         any_q      <= any_n;
         any_rise_q <= rise_n;
      end
   end

   // Event counter. clr wins over a coincident rise, dropping that event;
   // at all-ones the counter holds rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt_q <= '0;
      end else if (bus.clr) begin
         evt_cnt_q <= '0;
      end else if (rise_n && (evt_cnt_q != {CNT_W{1'b1}})) begin
         evt_cnt_q <= evt_cnt_q + CNT_W'(1);
      end
   end

   assign bus.e        = e_q;
   assign bus.f        = f_q;
   assign bus.g        = g_q;
   assign bus.any      = any_q;
   assign bus.any_rise = any_rise_q;
   assign bus.evt_cnt  = evt_cnt_q;

endmodule

// File: tb/tb_four_or.sv
// ---------------------------------------------------------------------------
// tb_four_or : scoreboard bench for four_or (WIDTH=4, CNT_W=2).
// The driver issues one input set per cycle on the falling edge and pushes
// the expected registered response; the monitor pops and compares one cycle
// later, just after the rising edge.
// ---------------------------------------------------------------------------
module tb_four_or;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int OUT_W   = 3 * WIDTH + 2 + CNT_W;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   four_or_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   four_or #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   logic [OUT_W-1:0] exp_q[$];
   int               n_cmp  = 0;
   int               n_fail = 0;

   // Reference model: previous "any" flag and a raw count of rise events
   // since the last clear; the visible count is that number capped at max.
   logic             m_any    = 1'b0;
   int               m_events = 0;

   function automatic logic [OUT_W-1:0] dut_out();
      return {bus.e, bus.f, bus.g, bus.any, bus.any_rise, bus.evt_cnt};
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [WIDTH-1:0] tc, input logic [WIDTH-1:0] td,
                       input logic tclr);
      logic [WIDTH-1:0] xe, xf, xg;
      logic             xany, xrise;
      int               shown;
      @(negedge clk);
      bus.a   = ta;
      bus.b   = tb_;
      bus.c   = tc;
      bus.d   = td;
      bus.clr = tclr;
      if (rst_n) begin
         xe    = ta | tb_;
         xf    = tc | td;
         xg    = xe | xf;
         xany  = (xg != '0);
         xrise = xany && !m_any;
         if (tclr)       m_events = 0;
         else if (xrise) m_events = m_events + 1;
         shown = (m_events > CNT_MAX) ? CNT_MAX : m_events;
         exp_q.push_back({xe, xf, xg, xany, xrise, CNT_W'(shown)});
         m_any = xany;
      end
   endtask

   task automatic step_a(input logic [WIDTH-1:0] ta, input logic tclr);
      step(ta, '0, '0, '0, tclr);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      logic [OUT_W-1:0] exp_v;
      #1;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check("outputs", 64'(dut_out()), 64'(exp_v));
      end
      if (rst_n) begin
         check("inv_g_eq_e_or_f", 64'(bus.g), 64'(bus.e | bus.f));
         check("inv_any_eq_or_g", 64'(bus.any), 64'(|bus.g));
         check("inv_rise_implies_any", 64'(bus.any_rise & ~bus.any), 64'(0));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n   = 1'b0;
      bus.a   = '1;
      bus.b   = '1;
      bus.c   = '1;
      bus.d   = '1;
      bus.clr = 1'b0;

      // Held in reset with all-ones operands: everything stays zero.
      repeat (3) @(posedge clk);
      #2;
      check("reset_hold_outputs", 64'(dut_out()), 64'(0));
      #1 rst_n = 1'b1;

      // Truth table on every bit lane, a toggling fastest, d slowest.
      for (int i = 0; i < 16; i++) begin
         step({WIDTH{i[0]}}, {WIDTH{i[1]}}, {WIDTH{i[2]}}, {WIDTH{i[3]}}, 1'b0);
      end

      // Bitwise independence.
      step(4'b0001, 4'b0010, 4'b0100, 4'b0000, 1'b0);
      step(4'b1000, 4'b0000, 4'b0000, 4'b0001, 1'b0);

      // Edge pulse: 3 idle, a=1 for 4, idle, a=1 again -> two rises.
      step_a('0, 1'b1);
      step_a('0, 1'b0);
      step_a('0, 1'b0);
      repeat (4) step_a(4'b0001, 1'b0);
      step_a('0, 1'b0);
      step_a(4'b0001, 1'b0);
      step_a('0, 1'b0);

      // Saturation: 5 rises with a 2-bit counter -> holds at 3.
      step_a('0, 1'b1);
      repeat (5) begin
         step_a(4'b0010, 1'b0);
         step_a('0, 1'b0);
      end
      // clr coincident with a rise: the event is dropped, count is 0.
      step_a(4'b0100, 1'b1);
      step_a('0, 1'b0);

      // Async reset mid-run with evt_cnt=2 and any=1.
      step_a('0, 1'b1);
      step_a(4'b0001, 1'b0);
      step_a('0, 1'b0);
      step_a(4'b0001, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'(dut_out()), 64'(0));
      check("async_reset_queue_empty", 64'(exp_q.size()), 64'(0));
      m_any    = 1'b0;
      m_events = 0;
      step_a(4'b0001, 1'b0);
      @(posedge clk);
      #2;
      check("reset_low_outputs", 64'(dut_out()), 64'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      // Inputs still nonzero: first cycle after release is a rise.
      step_a(4'b0001, 1'b0);
      step_a(4'b0001, 1'b0);

      // Randomized traffic, biased toward idle so rises recur.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            step('0, '0, '0, '0, ($urandom_range(0, 15) == 0));
         end else begin
            step(WIDTH'($urandom_range(0, 15)) & WIDTH'($urandom_range(0, 15)),
                 WIDTH'($urandom_range(0, 15)) & WIDTH'($urandom_range(0, 15)),
                 WIDTH'($urandom_range(0, 15)) & WIDTH'($urandom_range(0, 15)),
                 WIDTH'($urandom_range(0, 15)) & WIDTH'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
         end
      end

      @(posedge clk);
      #3;
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/four_or.md
Name: four_or

Overview:
- Registered bitwise OR tree combining four WIDTH-bit operands (a, b, c, d) through three 2-input OR stages.
- Exposes both intermediate pair results and the final result: e = a|b, f = c|d, g = e|f.
- Adds an "any bit set" flag, a rising-edge pulse on that flag and a saturating event counter.
- Leaf-level glue block used wherever several request/flag vectors must be merged.

Parameters:
- WIDTH, 1, bit width of each operand and of e/f/g.
- CNT_W, 8, width of the rising-edge event counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- a  input  WIDTH  operand 0
- b  input  WIDTH  operand 1
- c  input  WIDTH  operand 2
- d  input  WIDTH  operand 3
- clr  input  1  synchronous clear of event counter
- e  output  WIDTH  registered a|b
- f  output  WIDTH  registered c|d
- g  output  WIDTH  registered (a|b)|(c|d)
- any  output  1  registered reduction-OR of g's next value (|(a|b|c|d))
- any_rise  output  1  one-cycle pulse when any goes 0->1
- evt_cnt  output  CNT_W  count of any_rise pulses, saturating

Behaviour:
- Reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
  - rst_n=0 immediately forces e, f, g, any, any_rise and evt_cnt to 0, independent of clk.
  - Release is sampled normally on the next rising clk edge.
- Combinational core, bitwise per bit i:
  - e_n[i] = a[i]|b[i]
  - f_n[i] = c[i]|d[i]
  - g_n[i] = e_n[i]|f_n[i]
  - any_n = |g_n
- Latency: exactly 1 cycle. On each rising clk with rst_n=1, e<=e_n, f<=f_n, g<=g_n, any<=any_n. No enable; outputs track inputs every cycle.
- any_rise:
  - Registered any_rise <= any_n & ~any.
  - Asserts in the same cycle any first becomes 1, high for exactly one cycle.
  - Falls even if any stays 1.
- evt_cnt, each rising edge:
  - If clr=1, evt_cnt <= 0. clr has priority over a simultaneous rise event, so that event is dropped.
  - Else if (any_n & ~any), evt_cnt <= evt_cnt+1, unless evt_cnt = all-ones, in which case it holds (saturates, no wrap).
- Invariants checked every cycle after reset:
  - g == e|f
  - any == |g
  - any_rise implies any
- Reset mid-operation:
  - All registers clear asynchronously.
  - The first post-reset cycle with nonzero inputs counts as a rise event, because any was 0.
- Inputs are assumed synchronous to clk. No internal synchronizers.

Test Plan:
- Reset check: hold rst_n=0 with a=b=c=d=all-ones -> e=f=g=0, any=0, evt_cnt=0. Assert rst_n=0 between clock edges -> outputs clear without waiting for a clk edge.
- Exhaustive truth table with WIDTH=1: drive all 16 combinations of a,b,c,d (a toggling fastest, d slowest, one combination per cycle) -> one cycle later:
  - e=a|b, f=c|d, g=1 except for a=b=c=d=0.
  - Example: a=0,b=0,c=1,d=0 -> e=0, f=1, g=1.
- Bitwise independence with WIDTH=4: a=4'b0001, b=4'b0010, c=4'b0100, d=4'b0000 -> e=4'b0011, f=4'b0100, g=4'b0111, any=1.
- Edge pulse: inputs 0 for 3 cycles, then a=1 held 4 cycles, then 0, then a=1 again -> any_rise high exactly 2 single cycles, evt_cnt=2.
- Saturation and clr with CNT_W=2: generate 5 rise events -> evt_cnt reaches 3 and holds. Pulse clr in the same cycle as a rise -> evt_cnt=0.
- Async reset mid-run: evt_cnt=2 and any=1, pulse rst_n low between edges -> all outputs 0 at once. After release with inputs still nonzero -> any=1, any_rise=1, evt_cnt=1.
